au_decode_pipe: RTL and testbench

- Pipelined, flow-controlled binary-to-vector decoder, the sequential successor of the combinational arith-unit decoder.
- Converts a WIDTH-bit index into a 2**WIDTH-bit vector in one of four runtime-selectable modes.
- Has valid/ready handshakes on both sides and a parametrised pipeline depth.
- Sits between an index producer (e.g. shift-amount or priority logic) and mask consumers inside arithmetic datapaths.

---
 rtl/au_decode_pkg.sv | 14 +
 rtl/au_decode_core.sv | 67 ++++++
 rtl/au_decode_pipe.sv | 92 +++++++++
 tb/tb_au_decode_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/au_decode_pkg.sv
// Shared definitions for the pipelined index-to-vector decoder.
package au_decode_pkg;

  localparam logic [1:0] MODE_ONEHOT    = 2'b00;
  localparam logic [1:0] MODE_THERMO_LO = 2'b01;
  localparam logic [1:0] MODE_THERMO_HI = 2'b10;
  localparam logic [1:0] MODE_ONEHOT_N  = 2'b11;

  // Decoded vector width for a given index width.
  function automatic int unsigned out_w(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/au_decode_core.sv
// Combinational decode of an index into one-hot, thermometer or inverted one-hot.
module au_decode_core
  import au_decode_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned ARCH  = 0
) (
  input  logic [WIDTH-1:0]         a,
  input  logic [1:0]               mode,
  output logic [out_w(WIDTH)-1:0]  z
);

  localparam int unsigned N = out_w(WIDTH);

  logic [N-1:0] onehot;
  logic [N-1:0] thermo_lo;
  logic [N-1:0] thermo_hi;

  // Three equivalent one-hot decoder structures, chosen at elaboration.
  generate
    if (ARCH == 1) begin : g_cmp
      always_comb begin
        onehot = '0;
        for (int i = 0; i < int'(N); i++) begin
          onehot[i] = (WIDTH'(i) == a);
        end
      end
    end else if (ARCH == 2) begin : g_mux
      always_comb begin
        onehot = N'(1);
        for (int b = 0; b < int'(WIDTH); b++) begin
          if (a[b]) onehot = onehot << (1 << b);
        end
      end
    end else begin : g_shift
      assign onehot = N'(1) << a;
    end
  endgenerate

  // Thermo-low fills from the hot bit downward, thermo-high from it upward.
  always_comb begin
    logic acc_lo;
    logic acc_hi;
    acc_lo    = 1'b0;
    acc_hi    = 1'b0;
    thermo_lo = '0;
    thermo_hi = '0;
    for (int i = 0; i < int'(N); i++) begin
      acc_hi                    = acc_hi | onehot[i];
      thermo_hi[i]              = acc_hi;
      acc_lo                    = acc_lo | onehot[int'(N) - 1 - i];
      thermo_lo[int'(N) - 1 - i] = acc_lo;
    end
  end

  always_comb begin
    z = onehot;
    case (mode)
      MODE_ONEHOT:    z = onehot;
      MODE_THERMO_LO: z = thermo_lo;
      MODE_THERMO_HI: z = thermo_hi;
      MODE_ONEHOT_N:  z = ~onehot;
      default:        z = onehot;
    endcase
  end

endmodule

// File: rtl/au_decode_pipe.sv
// Valid/ready pipelined decoder: combinational decode feeding STAGES register slots.
module au_decode_pipe
  import au_decode_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned ARCH   = 0,
  parameter int unsigned STAGES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [out_w(WIDTH)-1:0]  out_z
);

  localparam int unsigned N = out_w(WIDTH);

  generate
    if (WIDTH < 1 || STAGES < 1 || STAGES > 4 || ARCH > 2) begin : g_param_check
      $error("au_decode_pipe: illegal parameters WIDTH=%0d ARCH=%0d STAGES=%0d",
             WIDTH, ARCH, STAGES);
    end
  endgenerate

  logic [N-1:0]              dec_z;
  logic [STAGES-1:0]         slot_valid;
  logic [STAGES-1:0][N-1:0]  slot_z;
  logic [STAGES:0]           slot_rdy;

  au_decode_core #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_core (
    .a    (in_a),
    .mode (in_mode),
    .z    (dec_z)
  );

  // Ready chain: a slot can load when it is empty or its successor can load.
  always_comb begin
    slot_rdy         = '0;
    slot_rdy[STAGES] = out_ready;
    for (int s = int'(STAGES) - 1; s >= 0; s--) begin
      slot_rdy[s] = !slot_valid[s] || slot_rdy[s+1];
    end
  end

  for (genvar s = 0; s < int'(STAGES); s++) begin : g_slot
    logic          valid_q, valid_d, src_valid;
    logic [N-1:0]  z_q, z_d, src_z;

    if (s == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_z     = dec_z;
    end else begin : g_body
      assign src_valid = slot_valid[s-1];
      assign src_z     = slot_z[s-1];
    end

    // Empty slots carry zero data so an idle output reads as 0.
    always_comb begin
      valid_d = valid_q;
      z_d     = z_q;
      if (slot_rdy[s]) begin
        valid_d = src_valid;
        z_d     = src_valid ? src_z : '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        z_q     <= '0;
      end else begin
        valid_q <= valid_d;
        z_q     <= z_d;
      end
    end

    assign slot_valid[s] = valid_q;
    assign slot_z[s]     = z_q;
  end

  assign in_ready  = slot_rdy[0];
  assign out_valid = slot_valid[STAGES-1];
  assign out_z     = slot_z[STAGES-1];

endmodule

// File: tb/tb_au_decode_pipe.sv
// Directed and randomised bench for au_decode_pipe across depths, architectures and widths.
module tb_au_decode_pipe;

  logic clk;
  logic rst;

  // Instances 0..2: WIDTH=3 with (ARCH,STAGES) = (0,1), (1,3), (2,2).
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [2:0] in_a      [3];
  logic [1:0] in_mode   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] out_z     [3];

  logic       w1_in_valid, w1_in_ready, w1_in_a, w1_out_valid, w1_out_ready;
  logic [1:0] w1_in_mode, w1_out_z;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_data [4][2048];
  int         sb_wr   [4];
  int         sb_rd   [4];
  logic       hold_v  [4];
  logic [7:0] hold_z  [4];

  au_decode_pipe #(.WIDTH(3), .ARCH(0), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_mode(in_mode[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_z(out_z[0]));

  au_decode_pipe #(.WIDTH(3), .ARCH(1), .STAGES(3)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_mode(in_mode[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_z(out_z[1]));

  au_decode_pipe #(.WIDTH(3), .ARCH(2), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_mode(in_mode[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_z(out_z[2]));

  au_decode_pipe #(.WIDTH(1), .ARCH(0), .STAGES(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .in_a(w1_in_a), .in_mode(w1_in_mode), .out_valid(w1_out_valid),
    .out_ready(w1_out_ready), .out_z(w1_out_z));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit i of the result straight from the mode's comparison rule.
  function automatic logic [7:0] ref_dec(input int w, input int k, input logic [1:0] m);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < (1 << w); i++) begin
      case (m)
        2'b00:   r[i] = (i == k);
        2'b01:   r[i] = (i <= k);
        2'b10:   r[i] = (i >= k);
        default: r[i] = (i != k);
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    for (int d = 0; d < 4; d++) begin
      sb_wr[d]  = 0;
      sb_rd[d]  = 0;
      hold_v[d] = 1'b0;
      hold_z[d] = '0;
    end
  endtask

  // Observe one cycle's transfers against the scoreboards, then advance one clock.
  task automatic step();
    logic       ov, ordy, iv, irdy;
    logic [7:0] oz, exp_z;
    #1;
    for (int d = 0; d < 4; d++) begin
      if (d < 3) begin
        ov = out_valid[d]; ordy = out_ready[d]; oz = out_z[d];
        iv = in_valid[d];  irdy = in_ready[d];
        exp_z = ref_dec(3, int'(in_a[d]), in_mode[d]);
      end else begin
        ov = w1_out_valid; ordy = w1_out_ready; oz = 8'(w1_out_z);
        iv = w1_in_valid;  irdy = w1_in_ready;
        exp_z = ref_dec(1, int'(w1_in_a), w1_in_mode);
      end
      if (hold_v[d]) begin
        chk($sformatf("hold_valid[%0d]", d), 32'(ov), 32'(1));
        chk($sformatf("hold_z[%0d]", d), 32'(oz), 32'(hold_z[d]));
      end
      if (!ov) chk($sformatf("idle_z[%0d]", d), 32'(oz), 32'(0));
      if (ov && ordy) begin
        chk($sformatf("sb_nonempty[%0d]", d), 32'(sb_wr[d] > sb_rd[d]), 32'(1));
        if (sb_wr[d] > sb_rd[d]) begin
          chk($sformatf("out_order[%0d]", d), 32'(oz), 32'(sb_data[d][sb_rd[d] % 2048]));
          sb_rd[d]++;
        end
      end
      hold_v[d] = ov && !ordy;
      hold_z[d] = oz;
      if (iv && irdy) begin
        sb_data[d][sb_wr[d] % 2048] = exp_z;
        sb_wr[d]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0] mt_a   [5];
  logic [1:0] mt_m   [5];
  logic [7:0] mt_exp [5];
  int         guard;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_a[d] = '0; in_mode[d] = '0; out_ready[d] = 1'b0;
    end
    w1_in_valid = 1'b0; w1_in_a = 1'b0; w1_in_mode = '0; w1_out_ready = 1'b0;
    clear_sb();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_out_valid[%0d]", d), 32'(out_valid[d]), 32'(0));
      chk($sformatf("rst_out_z[%0d]", d), 32'(out_z[d]), 32'(0));
      chk($sformatf("rst_in_ready[%0d]", d), 32'(in_ready[d]), 32'(1));
    end
    chk("rst_w1_out_valid", 32'(w1_out_valid), 32'(0));

    // Stream 0..7 one-hot through the single-stage pipe; each appears one cycle later.
    out_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid[0] = 1'b1; in_a[0] = 3'(i); in_mode[0] = 2'b00;
      step();
      chk($sformatf("stream_valid[%0d]", i), 32'(out_valid[0]), 32'(1));
      chk($sformatf("stream_z[%0d]", i), 32'(out_z[0]), 32'(8'd1 << i));
    end

    // Mode table including the all-ones boundaries.
    mt_a   = '{3'd5, 3'd5, 3'd5, 3'd7, 3'd0};
    mt_m   = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    mt_exp = '{8'h3F, 8'hE0, 8'hDF, 8'hFF, 8'hFF};
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1; in_a[0] = mt_a[i]; in_mode[0] = mt_m[i];
      step();
      chk($sformatf("mode_z[%0d]", i), 32'(out_z[0]), 32'(mt_exp[i]));
    end
    in_valid[0] = 1'b0;
    step();

    // Three-stage pipe: fill against a stalled consumer, then release.
    out_ready[1] = 1'b0; in_valid[1] = 1'b1; in_mode[1] = 2'b00;
    for (int i = 0; i < 8; i++) begin
      in_a[1] = 3'($urandom);
      step();
    end
    #1;
    chk("fill_accepts", 32'(sb_wr[1] - sb_rd[1]), 32'(3));
    chk("fill_in_ready", 32'(in_ready[1]), 32'(0));
    chk("fill_out_valid", 32'(out_valid[1]), 32'(1));
    out_ready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a[1] = 3'(i); in_mode[1] = 2'($urandom);
      step();
      chk($sformatf("no_gap[%0d]", i), 32'(out_valid[1]), 32'(1));
    end
    in_valid[1] = 1'b0;
    repeat (4) step();
    chk("drain_s3", 32'(sb_wr[1] - sb_rd[1]), 32'(0));

    // Reset with two items in flight in the two-stage pipe.
    out_ready[2] = 1'b0; in_valid[2] = 1'b1; in_mode[2] = 2'b01;
    for (int i = 0; i < 2; i++) begin
      in_a[2] = 3'(i + 2);
      step();
    end
    chk("inflight_valid", 32'(out_valid[2]), 32'(1));
    in_valid[2] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_sb();
    #1;
    chk("midrst_out_valid", 32'(out_valid[2]), 32'(0));
    chk("midrst_out_z", 32'(out_z[2]), 32'(0));
    chk("midrst_in_ready", 32'(in_ready[2]), 32'(1));
    out_ready[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("no_stale[%0d]", i), 32'(out_valid[2]), 32'(0));
    end

    // Random handshakes on all three architectures, 1000 items each.
    guard = 0;
    while ((sb_wr[0] < 1000 || sb_wr[1] < 1000 || sb_wr[2] < 1000) && guard < 20000) begin
      for (int d = 0; d < 3; d++) begin
        in_valid[d]  = (sb_wr[d] < 1000) && ($urandom_range(0, 2) != 0);
        in_a[d]      = 3'($urandom);
        in_mode[d]   = 2'($urandom);
        out_ready[d] = ($urandom_range(0, 3) != 0);
      end
      step();
      guard++;
    end
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    end
    repeat (8) step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rand_accepted[%0d]", d), 32'(sb_wr[d]), 32'(1000));
      chk($sformatf("rand_emitted[%0d]", d), 32'(sb_rd[d]), 32'(1000));
    end

    // WIDTH=1 corner cases with a=1.
    w1_out_ready = 1'b1; w1_in_valid = 1'b1; w1_in_a = 1'b1;
    w1_in_mode = 2'b00;
    step();
    chk("w1_onehot", 32'(w1_out_z), 32'(2'b10));
    w1_in_mode = 2'b10;
    step();
    chk("w1_thermo_hi", 32'(w1_out_z), 32'(2'b10));
    w1_in_mode = 2'b01;
    step();
    chk("w1_thermo_lo", 32'(w1_out_z), 32'(2'b11));
    w1_in_valid = 1'b0;
    step();
    chk("w1_drain", 32'(sb_wr[3] - sb_rd[3]), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
